dev_stream_packer: RTL and testbench

- Upstream feeder for the reshuffler. It collects narrow DataWidth-wide stream beats into one SpatPar*DataWidth vector, which drives the reshuffler's a_i/a_valid_i/a_ready_o port.
- Uses valid-ready on both sides. A last flag closes a partial vector, and the unused lanes are zero-padded.
- One fill buffer plus one output register, so input can continue while a packed vector waits downstream.

---
 rtl/dev_stream_packer_pkg.sv | 15 +
 rtl/dev_stream_packer_outreg.sv | 54 +++++
 rtl/dev_stream_packer.sv | 164 ++++++++++++++++
 tb/tb_dev_stream_packer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dev_stream_packer_pkg.sv
// Shared types and helpers for the stream packer.
package dev_stream_packer_pkg;

    // Fill-side state: FILL accepts beats, HOLD parks a completed vector.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } fill_state_e;

    // Width needed to hold a lane count in the range 0..spat_par.
    function automatic int lane_cnt_width(input int spat_par);
        return $clog2(spat_par + 1);
    endfunction

endpackage

// File: rtl/dev_stream_packer_outreg.sv
// Single-entry valid/ready output register with a load port.
// The parent only asserts i_load when this register is empty or drains
// in the same cycle, so a load never overwrites an unconsumed vector.
module dev_stream_packer_outreg
    import dev_stream_packer_pkg::*;
#(
    parameter int DataW = 512,
    parameter int CntW  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_load,
    input  logic [DataW-1:0] i_data,
    input  logic [CntW-1:0]  i_count,
    input  logic             i_last,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [DataW-1:0] o_data,
    output logic [CntW-1:0]  o_count,
    output logic             o_last
);

    logic             r_valid;
    logic [DataW-1:0] r_data;
    logic [CntW-1:0]  r_count;
    logic             r_last;

    // Hold the vector until the consumer takes it; a load wins over a drain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (rst_i) begin
            r_valid <= 1'b0;
            // NOTE: the wide data register is cleared too because the
            // interface promises out_data_o=0 out of reset.
            r_data  <= '0;
            r_count <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_count <= i_count;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_count = r_count;
    assign o_last  = r_last;

endmodule

// File: rtl/dev_stream_packer.sv
// Packs DataWidth-wide stream beats into SpatPar-lane vectors. A fill
// buffer collects beats while the output register presents the previous
// vector, so input keeps flowing during one vector of downstream stall.
module dev_stream_packer
    import dev_stream_packer_pkg::*;
#(
    parameter int SpatPar   = 8,
    parameter int DataWidth = 64,
    parameter int OutWidth  = SpatPar * DataWidth,
    parameter int CntWidth  = lane_cnt_width(SpatPar)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DataWidth-1:0] in_data_i,
    input  logic                 in_valid_i,
    input  logic                 in_last_i,
    output logic                 in_ready_o,
    output logic [OutWidth-1:0]  out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [CntWidth-1:0]  out_count_o,
    output logic                 out_last_o,
    output logic [31:0]          vec_cnt_o
);

    fill_state_e          r_state;
    fill_state_e          w_state_next;
    logic [CntWidth-1:0]  r_idx;
    logic [OutWidth-1:0]  r_buf;
    logic [CntWidth-1:0]  r_hold_count;
    logic                 r_hold_last;
    logic [31:0]          r_vec_cnt;

    logic                 w_in_hs;
    logic                 w_out_hs;
    logic                 w_out_free;
    logic                 w_complete;
    logic [OutWidth-1:0]  w_packed;
    logic                 w_load;
    logic [OutWidth-1:0]  w_load_data;
    logic [CntWidth-1:0]  w_load_count;
    logic                 w_load_last;

    // Ready depends on registered state only, never on out_ready_i.
    assign in_ready_o = (r_state == FILL);
    assign w_in_hs    = in_valid_i && in_ready_o;
    assign w_out_hs   = out_valid_o && out_ready_i;
    assign w_out_free = !out_valid_o || out_ready_i;
    assign w_complete = w_in_hs && ((r_idx == CntWidth'(SpatPar - 1)) || in_last_i);

    // Current fill buffer with the incoming beat dropped into lane r_idx.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        w_packed = r_buf;
        for (int k = 0; k < SpatPar; k++) begin
            if (r_idx == CntWidth'(k)) begin
                w_packed[k*DataWidth +: DataWidth] = in_data_i;
            end
        end
    end

    // Fill-state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next fill state and output-register load selection.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_data  = w_packed;
        w_load_count = r_idx + CntWidth'(1);
        w_load_last  = in_last_i;
        case (r_state)
            FILL: begin
                if (w_complete) begin
                    if (w_out_free) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                w_load_data  = r_buf;
                w_load_count = r_hold_count;
                w_load_last  = r_hold_last;
                if (w_out_hs) begin
                    w_load       = 1'b1;
                    w_state_next = FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    // Lane index and fill buffer: accumulate beats, park or clear on completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx        <= '0;
            r_buf        <= '0;
            r_hold_count <= '0;
            r_hold_last  <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_complete) begin
                        r_idx <= '0;
                        if (w_out_free) begin
                            r_buf <= '0;
                        end else begin
                            r_buf        <= w_packed;
                            r_hold_count <= w_load_count;
                            r_hold_last  <= in_last_i;
                        end
                    end else if (w_in_hs) begin
                        r_idx <= r_idx + CntWidth'(1);
                        r_buf <= w_packed;
                    end
                end
                HOLD: begin
                    if (w_out_hs) begin
                        r_buf <= '0;
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

    // Count delivered vectors; wraps naturally at 2^32.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vec_cnt <= '0;
        end else if (w_out_hs) begin
            r_vec_cnt <= r_vec_cnt + 32'd1;
        end
    end

    assign vec_cnt_o = r_vec_cnt;

    dev_stream_packer_outreg #(
        .DataW (OutWidth),
        .CntW  (CntWidth)
    ) u_outreg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_count (w_load_count),
        .i_last  (w_load_last),
        .i_ready (out_ready_i),
        .o_valid (out_valid_o),
        .o_data  (out_data_o),
        .o_count (out_count_o),
        .o_last  (out_last_o)
    );

endmodule

// File: tb/tb_dev_stream_packer.sv
// Self-checking bench for dev_stream_packer: directed scenarios plus a
// randomized run, all compared against a queue-based frame model.
module tb_dev_stream_packer;

    localparam int SPAT = 8;
    localparam int DW   = 64;
    localparam int OW   = SPAT * DW;
    localparam int CW   = 4;

    typedef struct packed {
        logic [OW-1:0] data;
        logic [CW-1:0] cnt;
        logic          last;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [DW-1:0] in_data_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_last_i = 1'b0;
    logic          in_ready_o;
    logic [OW-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [CW-1:0] out_count_o;
    logic          out_last_o;
    logic [31:0]   vec_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] mdl_lanes[$];
    vec_t          exp_q[$];
    vec_t          obs_q[$];
    int            exp_total = 0;

    always #5 clk_i = ~clk_i;

    dev_stream_packer #(.SpatPar(SPAT), .DataWidth(DW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_count_o (out_count_o),
        .out_last_o  (out_last_o),
        .vec_cnt_o   (vec_cnt_o)
    );

    // Reference: collect accepted beats per frame; emit on SPAT beats or last.
    task automatic model_beat(input logic [DW-1:0] d, input logic l);
        vec_t v;
        mdl_lanes.push_back(d);
        if (mdl_lanes.size() == SPAT || l) begin
            v.data = '0;
            for (int i = 0; i < mdl_lanes.size(); i++) v.data[i*DW +: DW] = mdl_lanes[i];
            v.cnt  = CW'(mdl_lanes.size());
            v.last = l;
            exp_q.push_back(v);
            exp_total++;
            mdl_lanes.delete();
        end
    endtask

    task automatic model_reset();
        mdl_lanes.delete();
        exp_q.delete();
        obs_q.delete();
        exp_total = 0;
    endtask

    // One cycle: drive inputs just after an edge, note handshakes, advance.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                        input logic r, output bit hs_in);
        vec_t o;
        in_valid_i  = v;
        in_data_i   = d;
        in_last_i   = l;
        out_ready_i = r;
        hs_in = v && in_ready_o;
        if (r && out_valid_o) begin
            o = {out_data_o, out_count_o, out_last_o};
            obs_q.push_back(o);
        end
        if (hs_in) model_beat(d, l);
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        rst_i = 1'b1;
        model_reset();
        #2;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic drain();
        bit hs;
        int guard = 0;
        while ((obs_q.size() < exp_q.size() || out_valid_o) && guard < 64) begin
            step(1'b0, '0, 1'b0, 1'b1, hs);
            guard++;
        end
        n_vec++;
        if (guard >= 64) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d vectors, want %0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if ({out_valid_o, out_count_o, out_last_o, in_ready_o} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_ctrl: got v=%b c=%0d l=%b rdy=%b want v=0 c=0 l=0 rdy=1",
                     out_valid_o, out_count_o, out_last_o, in_ready_o);
        end
        n_vec++;
        if (out_data_o !== '0 || vec_cnt_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_data: got data=%h vec_cnt=%0d want 0/0", out_data_o, vec_cnt_o);
        end
    endtask

    task automatic test_full_vector();
        bit hs;
        for (int k = 0; k < SPAT; k++) step(1'b1, DW'(k), 1'b0, 1'b1, hs);
        n_vec++;
        if (out_valid_o !== 1'b1 || out_count_o !== 4'd8 || out_last_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_latency: got v=%b c=%0d l=%b want v=1 c=8 l=0",
                     out_valid_o, out_count_o, out_last_o);
        end
        for (int k = 0; k < SPAT; k++) begin
            n_vec++;
            if (out_data_o[k*DW +: DW] !== DW'(k)) begin
                n_err++;
                $display("FAIL full_lane%0d: got %h want %h", k, out_data_o[k*DW +: DW], DW'(k));
            end
        end
        drain();
        n_vec++;
        if (vec_cnt_o !== 32'd1) begin
            n_err++;
            $display("FAIL full_vec_cnt: got %0d want 1", vec_cnt_o);
        end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL full_num: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL full_vec%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_partial();
        bit hs;
        step(1'b1, 64'hA, 1'b0, 1'b1, hs);
        step(1'b1, 64'hB, 1'b0, 1'b1, hs);
        step(1'b1, 64'hC, 1'b1, 1'b1, hs);
        n_vec++;
        if (out_valid_o !== 1'b1 || out_count_o !== 4'd3 || out_last_o !== 1'b1 ||
            out_data_o[OW-1:3*DW] !== '0 || out_data_o[3*DW-1:0] !== {64'hC, 64'hB, 64'hA}) begin
            n_err++;
            $display("FAIL partial: got v=%b c=%0d l=%b data=%h want v=1 c=3 l=1 lanes A,B,C then zero",
                     out_valid_o, out_count_o, out_last_o, out_data_o);
        end
        drain();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL partial_num: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL partial_vec%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        bit hs;
        int idx = 0;
        int guard = 0;
        while (idx < 16 && guard < 40) begin
            step(1'b1, DW'(idx), 1'b0, 1'b0, hs);
            if (hs) idx++;
            guard++;
        end
        n_vec++;
        if (idx != 16 || guard != 16) begin
            n_err++;
            $display("FAIL bp_accept: got %0d beats in %0d cycles want 16 in 16", idx, guard);
        end
        n_vec++;
        if (in_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold_ready: got %b want 0", in_ready_o);
        end
        step(1'b0, '0, 1'b0, 1'b1, hs);
        n_vec++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=1", in_ready_o, out_valid_o);
        end
        drain();
        n_vec++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            n_err++;
            $display("FAIL bp_num: got %0d want 2 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL bp_vec%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit hs;
        int acc = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, DW'(i), 1'b0, (i == 15 || i == 23), hs);
            if (hs) acc++;
        end
        n_vec++;
        if (acc != 24) begin
            n_err++;
            $display("FAIL b2b_accept: got %0d beats want 24", acc);
        end
        drain();
        n_vec++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            n_err++;
            $display("FAIL b2b_num: got %0d want 3 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL b2b_vec%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit hs;
        for (int i = 0; i < 13; i++) step(1'b1, DW'(64'h100 + i), 1'b0, 1'b0, hs);
        apply_reset();
        n_vec++;
        if ({out_valid_o, out_count_o, out_last_o, in_ready_o} !== {1'b0, 4'd0, 1'b0, 1'b1} ||
            out_data_o !== '0 || vec_cnt_o !== 32'd0) begin
            n_err++;
            $display("FAIL midrst_state: got v=%b c=%0d l=%b rdy=%b cnt=%0d want 0,0,0,1,0",
                     out_valid_o, out_count_o, out_last_o, in_ready_o, vec_cnt_o);
        end
        for (int i = 0; i < SPAT; i++) step(1'b1, DW'(64'h10 + i), 1'b0, 1'b1, hs);
        n_vec++;
        if (out_valid_o !== 1'b1 || out_data_o[DW-1:0] !== 64'h10 || out_count_o !== 4'd8) begin
            n_err++;
            $display("FAIL midrst_lane0: got v=%b lane0=%h c=%0d want 1,10,8",
                     out_valid_o, out_data_o[DW-1:0], out_count_o);
        end
        drain();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL midrst_num: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL midrst_vec%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_single_beat();
        bit hs;
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b1, DW'(64'hBEEF0 + i), 1'b1, 1'b1, hs);
        drain();
        n_vec++;
        if (vec_cnt_o !== 32'd3 || obs_q.size() != 3) begin
            n_err++;
            $display("FAIL single_cnt: got vec_cnt=%0d obs=%0d want 3/3", vec_cnt_o, obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i] || obs_q[i].cnt !== 4'd1 || obs_q[i].last !== 1'b1) begin
                n_err++;
                $display("FAIL single_vec%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        bit   hs;
        bit   held;
        vec_t snap;
        vec_t now_v;
        logic v, l, r;
        logic [DW-1:0] d;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 2) != 0);
            d = {$urandom, $urandom};
            held = out_valid_o && !r;
            snap = {out_data_o, out_count_o, out_last_o};
            step(v, d, l, r, hs);
            if (held) begin
                now_v = {out_data_o, out_count_o, out_last_o};
                n_vec++;
                if (out_valid_o !== 1'b1 || now_v !== snap) begin
                    n_err++;
                    $display("FAIL rnd_stable@%0d: got v=%b %h want v=1 %h", c, out_valid_o, now_v, snap);
                end
            end
        end
        drain();
        n_vec++;
        if (obs_q.size() != exp_q.size() || vec_cnt_o !== 32'(exp_total)) begin
            n_err++;
            $display("FAIL rnd_num: got %0d vectors cnt=%0d want %0d cnt=%0d",
                     obs_q.size(), vec_cnt_o, exp_q.size(), exp_total);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rnd_vec%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_full_vector();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_single_beat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
